// File: rtl/load_store_unit.sv
// Load/store stage: one Wishbone transfer per control_unit request.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing them.
package lsu_pkg;
  typedef enum logic [1:0] {
    MEM_NONE   = 2'd0,
    LOAD_DATA  = 2'd1,
    STORE_DATA = 2'd2
  } memory_operation_t;
endpackage

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc,
  input  memory_operation_t memory_operation,
  input  logic [2:0]        funct3,
  input  logic [31:0]       address,
  input  logic [31:0]       store_data,
  output logic              ack,
  output logic              data_valid,
  output logic [31:0]       load_data,
  output logic              misaligned,
  output logic              bus_err,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [31:0]       wb_adr,
  output logic [3:0]        wb_sel,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_ACK,
    S_VALID
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    lo_q;
  logic          ld_op_q;
  logic          mis_q;
  logic          err_q;
  logic [31:0]   ld_q;

  logic          req;
  logic          is_b;
  logic          is_h;
  logic [3:0]    sel_nx;
  logic [31:0]   dat_nx;
  logic          mis_nx;
  logic          skip;
  logic          tmo;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic [31:0]   ext;

  assign req  = cyc && (memory_operation != MEM_NONE);
  assign is_b = (funct3[1:0] == 2'b00);
  assign is_h = (funct3[1:0] == 2'b01);
  assign skip = TRAP && mis_nx;
  assign tmo  = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    sel_nx = 4'b1111;
    dat_nx = store_data;
    mis_nx = 1'b0;
    unique case (1'b1)
      is_b: begin
        sel_nx = 4'b0001 << address[1:0];
        dat_nx = {4{store_data[7:0]}};
      end
      is_h: begin
        sel_nx = 4'b0011 << {address[1], 1'b0};
        dat_nx = {2{store_data[15:0]}};
        mis_nx = address[0];
      end
      default: mis_nx = |address[1:0];
    endcase
  end

  // Lane pick uses the request's low address bits; bit 2 of funct3 = unsigned.
  always_comb begin
    lb  = wb_dat_i[{lo_q, 3'b000} +: 8];
    lh  = lo_q[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];
    ext = wb_dat_i;
    unique case (1'b1)
      (f3_q[1:0] == 2'b00):
        ext = {{24{~f3_q[2] & lb[7]}}, lb};
      (f3_q[1:0] == 2'b01):
        ext = {{16{~f3_q[2] & lh[15]}}, lh};
      default: ext = wb_dat_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (req) state_nx = skip ? S_ACK : S_BUS;
      S_BUS:
        if (wb_ack || tmo) state_nx = S_ACK;
      S_ACK:
        if (!cyc) state_nx = ld_op_q ? S_VALID : S_IDLE;
      S_VALID:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ack        = 1'b0;
    data_valid = 1'b0;
    wb_cyc     = 1'b0;
    unique case (state)
      S_BUS:   wb_cyc     = 1'b1;
      S_ACK:   ack        = 1'b1;
      S_VALID: data_valid = 1'b1;
      default: ;
    endcase
  end

  assign wb_stb     = wb_cyc;
  assign misaligned = mis_q;
  assign bus_err    = err_q;
  assign load_data  = ld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      f3_q     <= '0;
      lo_q     <= '0;
      ld_op_q  <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
      ld_q     <= '0;
      wb_we    <= 1'b0;
      wb_adr   <= '0;
      wb_sel   <= '0;
      wb_dat_o <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (req) begin
          f3_q     <= funct3;
          lo_q     <= address[1:0];
          ld_op_q  <= (memory_operation == LOAD_DATA);
          wb_we    <= (memory_operation == STORE_DATA);
          wb_adr   <= {address[31:2], 2'b00};
          wb_sel   <= sel_nx;
          wb_dat_o <= dat_nx;
          cnt      <= '0;
          mis_q    <= skip;
          err_q    <= 1'b0;
          if (skip) ld_q <= '0;
        end
        S_BUS: begin
          cnt <= cnt + 1'b1;
          if (wb_ack) begin
            if (ld_op_q) ld_q <= ext;
          end else if (tmo) begin
            err_q <= 1'b1;
            ld_q  <= '0;
          end
        end
        default: if (state_nx == S_IDLE) begin
          mis_q <= 1'b0;
          err_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with an inline Wishbone slave.
// Honours LSU_MISALIGN_TRAP_EN for the misaligned-word expectation.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              cyc;
  memory_operation_t memory_operation;
  logic [2:0]        funct3;
  logic [31:0]       address;
  logic [31:0]       store_data;
  logic              ack;
  logic              data_valid;
  logic [31:0]       load_data;
  logic              misaligned;
  logic              bus_err;
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [31:0]       wb_adr;
  logic [3:0]        wb_sel;
  logic [31:0]       wb_dat_o;
  logic [31:0]       wb_dat_i;
  logic              wb_ack;

  int n_cmp = 0;
  int n_err = 0;

  int          lat, nbus;
  logic [3:0]  c_sel;
  logic [31:0] c_adr, c_dat, r_ld;
  logic        c_we, r_mis, r_err, r_dv0, r_dv, r_dv2, r_err2;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .cyc(cyc),
    .memory_operation(memory_operation),
    .funct3(funct3), .address(address),
    .store_data(store_data), .ack(ack),
    .data_valid(data_valid), .load_data(load_data),
    .misaligned(misaligned), .bus_err(bus_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_sel(wb_sel),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h required 0x%08h",
             tag, obs, exp);
    end
  endtask

  task automatic run(input memory_operation_t op,
                     input logic [2:0] f3,
                     input logic [31:0] adr,
                     input logic [31:0] sd,
                     input int ws,
                     input bit ack_en,
                     input logic [31:0] rd);
    int k;
    int nb;
    @(negedge clk);
    cyc = 1'b1;
    memory_operation = op;
    funct3 = f3;
    address = adr;
    store_data = sd;
    nb = 0;
    k = 0;
    lat = -1;
    while (lat < 0 && k < 40) begin
      @(negedge clk);
      k++;
      if (ack) lat = k;
      else if (wb_cyc) begin
        nb++;
        c_sel = wb_sel;
        c_adr = wb_adr;
        c_we = wb_we;
        c_dat = wb_dat_o;
        wb_ack = ack_en && (nb > ws);
        wb_dat_i = rd;
      end else wb_ack = 1'b0;
    end
    wb_ack = 1'b0;
    nbus = nb;
    r_mis = misaligned;
    r_err = bus_err;
    r_dv0 = data_valid;
    cyc = 1'b0;
    memory_operation = MEM_NONE;
    @(negedge clk);
    r_dv = data_valid;
    r_ld = load_data;
    @(negedge clk);
    r_dv2 = data_valid;
    r_err2 = bus_err;
  endtask

  initial begin
    rst = 1'b1;
    cyc = 1'b0;
    memory_operation = MEM_NONE;
    funct3 = 3'b000;
    address = '0;
    store_data = '0;
    wb_dat_i = '0;
    wb_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst ack", ack, 0);
    chk("rst data_valid", data_valid, 0);
    chk("rst wb_cyc", wb_cyc, 0);
    chk("rst wb_stb", wb_stb, 0);
    chk("rst wb_we", wb_we, 0);
    chk("rst wb_adr", wb_adr, 0);
    chk("rst wb_sel", wb_sel, 0);
    chk("rst wb_dat_o", wb_dat_o, 0);
    chk("rst load_data", load_data, 0);
    chk("rst misaligned", misaligned, 0);
    chk("rst bus_err", bus_err, 0);
    rst = 1'b0;

    @(negedge clk);
    cyc = 1'b1;
    memory_operation = MEM_NONE;
    repeat (3) begin
      @(negedge clk);
      chk("none wb_cyc", wb_cyc, 0);
      chk("none ack", ack, 0);
    end
    cyc = 1'b0;

    run(STORE_DATA, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 0);
    chk("sw latency", lat, 2);
    chk("sw bus cycles", nbus, 1);
    chk("sw sel", c_sel, 4'b1111);
    chk("sw we", c_we, 1);
    chk("sw adr", c_adr, 32'h100);
    chk("sw dat", c_dat, 32'hDEADBEEF);
    chk("sw bus_err", r_err, 0);
    chk("sw no data_valid", r_dv, 0);

    run(LOAD_DATA, 3'b000, 32'h103, 0, 0, 1, 32'h80FFFF00);
    chk("lb latency", lat, 2);
    chk("lb sel", c_sel, 4'b1000);
    chk("lb we", c_we, 0);
    chk("lb adr", c_adr, 32'h100);
    chk("lb dv during ack", r_dv0, 0);
    chk("lb data_valid", r_dv, 1);
    chk("lb load_data", r_ld, 32'hFFFFFF80);
    chk("lb dv one cycle", r_dv2, 0);

    run(LOAD_DATA, 3'b101, 32'h102, 0, 3, 1, 32'h80010000);
    chk("lhu latency", lat, 5);
    chk("lhu bus cycles", nbus, 4);
    chk("lhu sel", c_sel, 4'b1100);
    chk("lhu load_data", r_ld, 32'h00008001);
    chk("lhu data_valid", r_dv, 1);

    run(STORE_DATA, 3'b000, 32'h101, 32'h0000005A, 0, 1, 0);
    chk("sb sel", c_sel, 4'b0010);
    chk("sb dat", c_dat, 32'h5A5A5A5A);
    chk("sb adr", c_adr, 32'h100);

    run(LOAD_DATA, 3'b001, 32'h100, 0, 0, 1, 32'h12348765);
    chk("lh sel", c_sel, 4'b0011);
    chk("lh load_data", r_ld, 32'hFFFF8765);

    run(LOAD_DATA, 3'b100, 32'h102, 0, 1, 1, 32'h00AB0000);
    chk("lbu sel", c_sel, 4'b0100);
    chk("lbu load_data", r_ld, 32'h000000AB);

    run(LOAD_DATA, 3'b010, 32'h104, 0, 0, 0, 32'h55555555);
    chk("tmo bus cycles", nbus, 4);
    chk("tmo latency", lat, 5);
    chk("tmo bus_err", r_err, 1);
    chk("tmo load_data", r_ld, 0);
    chk("tmo data_valid", r_dv, 1);
    chk("tmo bus_err clear", r_err2, 0);

    run(LOAD_DATA, 3'b010, 32'h102, 0, 0, 1, 32'h11223344);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis bus cycles", nbus, 0);
    chk("mis latency", lat, 1);
    chk("mis flag", r_mis, 1);
    chk("mis load_data", r_ld, 0);
    chk("mis data_valid", r_dv, 1);
`else
    chk("mis bus cycles", nbus, 1);
    chk("mis adr", c_adr, 32'h100);
    chk("mis sel", c_sel, 4'b1111);
    chk("mis flag", r_mis, 0);
    chk("mis load_data", r_ld, 32'h11223344);
`endif

    run(LOAD_DATA, 3'b010, 32'h108, 0, 0, 1, 32'hCAFEF00D);
    chk("lw load_data", r_ld, 32'hCAFEF00D);

    @(negedge clk);
    cyc = 1'b1;
    memory_operation = LOAD_DATA;
    funct3 = 3'b010;
    address = 32'h200;
    @(negedge clk);
    chk("pre-rst wb_cyc", wb_cyc, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid-rst wb_cyc", wb_cyc, 0);
    chk("mid-rst wb_stb", wb_stb, 0);
    chk("mid-rst wb_adr", wb_adr, 0);
    chk("mid-rst load_data", load_data, 0);
    chk("mid-rst ack", ack, 0);
    cyc = 1'b0;
    memory_operation = MEM_NONE;
    @(negedge clk);
    rst = 1'b0;

    run(STORE_DATA, 3'b010, 32'h10C, 32'h01020304, 0, 1, 0);
    chk("post-rst latency", lat, 2);
    chk("post-rst adr", c_adr, 32'h10C);
    chk("post-rst dat", c_dat, 32'h01020304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
